// File: rtl/if_id_imm_decode.sv
// IF/ID pipeline register for the RV32I core. Captures PC/instruction and, on the
// same edge, the raw immediate fields and one-hot extender select for the ID stage.
module if_id_imm_decode #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [4:0]  iimm_shamt,
    output logic [11:0] iimm,
    output logic [11:0] simm,
    output logic [11:0] bimm,
    output logic [19:0] uimm,
    output logic [19:0] jimm,
    output logic [5:0]  EXTOp,
    output logic        illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;
    localparam logic [5:0] EXT_NONE  = 6'b000000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] dec_extop;
    logic       dec_illegal;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];

    always_comb begin
        dec_extop   = EXT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OP_IMM: begin
                // funct7 is deliberately ignored: srai/srli share the shamt path
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_extop = EXT_SHAMT;
                else
                    dec_extop = EXT_I;
            end
            OP_LOAD, OP_JALR:   dec_extop = EXT_I;
            OP_STORE:           dec_extop = EXT_S;
            OP_BRANCH:          dec_extop = EXT_B;
            OP_LUI, OP_AUIPC:   dec_extop = EXT_U;
            OP_JAL:             dec_extop = EXT_J;
            OP_REG, OP_SYSTEM:  dec_extop = EXT_NONE;
            default:            dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_pc      <= PC_RESET;
            id_instr   <= NOP_INSTR;
            iimm_shamt <= '0;
            iimm       <= '0;
            simm       <= '0;
            bimm       <= '0;
            uimm       <= '0;
            jimm       <= '0;
            EXTOp      <= EXT_NONE;
            illegal    <= 1'b0;
        end else if (flush || (!stall && !if_valid)) begin
            // bubble: flush wins over stall
            id_valid   <= 1'b0;
            id_pc      <= PC_RESET;
            id_instr   <= NOP_INSTR;
            iimm_shamt <= '0;
            iimm       <= '0;
            simm       <= '0;
            bimm       <= '0;
            uimm       <= '0;
            jimm       <= '0;
            EXTOp      <= EXT_NONE;
            illegal    <= 1'b0;
        end else if (!stall) begin
            id_valid   <= 1'b1;
            id_pc      <= if_pc;
            id_instr   <= if_instr;
            iimm_shamt <= if_instr[24:20];
            iimm       <= if_instr[31:20];
            simm       <= {if_instr[31:25], if_instr[11:7]};
            bimm       <= {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8]};
            uimm       <= if_instr[31:12];
            jimm       <= {if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21]};
            EXTOp      <= dec_extop;
            illegal    <= dec_illegal;
        end
    end

endmodule

// File: doc/if_id_imm_decode.md
Name: if_id_imm_decode

Overview:
IF/ID pipeline register with an integrated immediate-field decoder for the pipelined RV32I core. It captures the fetched instruction and PC, and in the same capture edge splits the instruction into the raw immediate fields and the one-hot EXTOp. These registered outputs feed the EXT immediate extender and the rest of the ID stage directly. Stall and flush inputs from the hazard unit control it.

Parameters:
PC_RESET, 32'h0000_0000, value id_pc takes on reset and on flush
NOP_INSTR, 32'h0000_0013, instruction word loaded on reset, flush and bubble (addi x0,x0,0)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active-high
stall  input  1  hold all ID registers (hazard unit)
flush  input  1  squash ID contents (branch/jump taken)
if_valid  input  1  fetch stage presents a valid instruction
if_pc  input  32  PC of fetched instruction
if_instr  input  32  fetched instruction word
id_valid  output  1  ID stage holds a real instruction
id_pc  output  32  registered PC
id_instr  output  32  registered instruction
iimm_shamt  output  5  instr[24:20]
iimm  output  12  instr[31:20]
simm  output  12  {instr[31:25], instr[11:7]}
bimm  output  12  {instr[31], instr[7], instr[30:25], instr[11:8]}
uimm  output  20  instr[31:12]
jimm  output  20  {instr[31], instr[19:12], instr[20], instr[30:21]}
EXTOp  output  6  one-hot extender select
illegal  output  1  valid instruction with unrecognised opcode

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency is 1 cycle: the fields and EXTOp for if_instr appear on the edge that captures it.
- Reset (async, rst=1) sets the following values immediately: id_valid=0, id_pc=PC_RESET, id_instr=NOP_INSTR, all imm fields=0, EXTOp=6'b000000, illegal=0.
- Per rising edge, in priority order:
  1. flush=1 loads a bubble. Flush overrides stall.
  2. stall=1: every register holds its value.
  3. if_valid=0 loads a bubble.
  4. Otherwise capture: id_valid=1, id_pc=if_pc, id_instr=if_instr, fields and EXTOp decoded from if_instr.
- Bubble: id_valid=0, id_pc=PC_RESET, id_instr=NOP_INSTR, all fields=0, EXTOp=0, illegal=0.
- Decode uses opcode = instr[6:0] and funct3 = instr[14:12]:
  - 0010011 with funct3 001 or 101 gives EXTOp 100000 (shift immediate). funct7 is not checked.
  - 0010011 with any other funct3, 0000011 (load) and 1100111 (jalr) give EXTOp 010000.
  - 0100011 (store) gives 001000.
  - 1100011 (branch) gives 000100.
  - 0110111 (lui) and 0010111 (auipc) give 000010.
  - 1101111 (jal) gives 000001.
  - 0110011 (R-type) and 1110011 (system) give 000000 with illegal=0.
  - Any other opcode gives 000000 with illegal=1.
- Field slicing is unconditional. All six fields are loaded on every capture, whatever the opcode.
- EXTOp is exactly one-hot or all-zero; two bits are never set together.
- Simultaneous stall and flush: the flush takes effect and a bubble is loaded.
- Reset asserted mid-cycle clears the outputs immediately. The first capture happens on the first rising edge after rst deasserts.

Test Plan:
- Reset: assert rst, then release. Required: id_valid=0, id_instr=32'h00000013, id_pc=0, EXTOp=0, all fields 0.
- if_pc=0x100, if_instr=0xFFF00093 (addi x1,x0,-1), if_valid=1, one edge. Required: id_valid=1, id_pc=0x100, iimm=0xFFF, EXTOp=010000, illegal=0.
- Branch beq -4, if_instr=0xFE000EE3. Required: bimm=0xFFE, EXTOp=000100.
- jal +8, if_instr=0x008000EF. Required: jimm=0x00004, EXTOp=000001.
- Shift immediates: slli x1,x1,3 (0x00309093), then srai x1,x1,3 (0x4030D093). Required for both: iimm_shamt=3, EXTOp=100000.
- Stall, flush and illegal opcode:
  - Hold stall=1 for 3 edges while if_instr changes. Required: outputs unchanged.
  - Then drive stall=1 and flush=1 together. Required: bubble (id_valid=0, id_instr=0x00000013).
  - Then drive if_instr=0x0000007F with if_valid=1. Required: illegal=1, EXTOp=0.
